// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB-first into a ccff chain; first bit one cycle after handshake, no bubble between words.
// Define CCFF_READBACK_EN to flush the chain and probe its length with a marker before loading.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cfg_start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = ((CHAIN_LEN % WORD_W) == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
    localparam int WC_W      = $clog2(N_WORDS + 1);
    localparam int BS_W      = $clog2(CHAIN_LEN + 1);
    localparam int BC_W      = $clog2(WORD_W + 1);

    localparam logic [WC_W-1:0] WC_INIT = WC_W'(N_WORDS);
    localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
    localparam logic [BS_W-1:0] BS_LAST = BS_W'(CHAIN_LEN);
    localparam logic [BS_W-1:0] BS_ONE  = BS_W'(1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(WORD_W - 1);
    localparam logic [BC_W-1:0] BC_TAIL = BC_W'(LAST_BITS - 1);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

`ifdef CCFF_READBACK_EN
    typedef enum logic [2:0] {ST_IDLE, ST_FLUSH, ST_PROBE, ST_LOAD, ST_ERR} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ERR} state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_buf;
    logic [BC_W-1:0]   r_buf_cnt;
    logic [WC_W-1:0]   r_words_left;
    logic [BS_W-1:0]   r_bits_sent;
    logic              r_head;
    logic              r_shift_en;
    logic              r_done;
    logic              w_accept;
    logic              w_last_shift;

`ifdef CCFF_READBACK_EN
    localparam int RB_W = $clog2(2 * CHAIN_LEN + 1);
    localparam logic [RB_W-1:0] RB_ONE = RB_W'(1);
    localparam logic [RB_W-1:0] RB_LEN = RB_W'(CHAIN_LEN);
    localparam logic [RB_W-1:0] RB_TMO = RB_W'(2 * CHAIN_LEN);

    logic [RB_W-1:0] r_rb_cnt;
    logic            r_error;
    logic            w_probe_ok;
    logic            w_probe_bad;

    // r_rb_cnt counts flush cycles, then cycles since the marker was driven
    assign w_probe_ok  = ccff_tail && (r_rb_cnt == RB_LEN);
    assign w_probe_bad = (ccff_tail && (r_rb_cnt != RB_LEN)) || (r_rb_cnt == RB_TMO);
    assign error       = r_error;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign error         = 1'b0;
`endif

    // r_buf_cnt counts bits still waiting behind the one currently on ccff_head
    assign cfg_ready     = (r_state == ST_LOAD) && (r_words_left != '0) && (r_buf_cnt == '0);
    assign w_accept      = cfg_ready && cfg_valid;
    assign w_last_shift  = r_shift_en && (r_bits_sent == BS_LAST);
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign done          = r_done;
    assign busy          = (r_state != ST_IDLE);

    always_ff @(posedge prog_clk) begin
        if (pReset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) begin
`ifdef CCFF_READBACK_EN
                    w_state_nxt = ST_FLUSH;
`else
                    w_state_nxt = ST_LOAD;
`endif
                end
            end
`ifdef CCFF_READBACK_EN
            ST_FLUSH: if (r_rb_cnt == RB_LEN) w_state_nxt = ST_PROBE;
            ST_PROBE: begin
                if (w_probe_ok)       w_state_nxt = ST_LOAD;
                else if (w_probe_bad) w_state_nxt = ST_ERR;
            end
`endif
            ST_LOAD: if (w_last_shift) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_head       <= 1'b0;
            r_shift_en   <= 1'b0;
            r_done       <= 1'b0;
            r_buf        <= '0;
            r_buf_cnt    <= '0;
            r_words_left <= '0;
            r_bits_sent  <= '0;
`ifdef CCFF_READBACK_EN
            r_rb_cnt     <= '0;
            r_error      <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_shift_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        r_words_left <= WC_INIT;
                        r_bits_sent  <= '0;
                        r_buf_cnt    <= '0;
`ifdef CCFF_READBACK_EN
                        r_error      <= 1'b0;
                        r_rb_cnt     <= RB_ONE;
                        r_head       <= 1'b0;
                        r_shift_en   <= 1'b1;
`endif
                    end
                end
`ifdef CCFF_READBACK_EN
                ST_FLUSH: begin
                    r_shift_en <= 1'b1;
                    if (r_rb_cnt == RB_LEN) begin
                        r_head   <= 1'b1;
                        r_rb_cnt <= '0;
                    end else begin
                        r_head   <= 1'b0;
                        r_rb_cnt <= r_rb_cnt + RB_ONE;
                    end
                end
                ST_PROBE: begin
                    if (w_probe_bad && !w_probe_ok) begin
                        r_error <= 1'b1;
                    end else if (!w_probe_ok) begin
                        r_shift_en <= 1'b1;
                        r_head     <= 1'b0;
                        r_rb_cnt   <= r_rb_cnt + RB_ONE;
                    end
                end
`endif
                ST_LOAD: begin
                    if (w_last_shift) begin
                        r_done <= 1'b1;
                    end else if (r_buf_cnt != '0) begin
                        r_head      <= r_buf[WORD_W-1];
                        r_buf       <= r_buf << 1;
                        r_buf_cnt   <= r_buf_cnt - BC_ONE;
                        r_bits_sent <= r_bits_sent + BS_ONE;
                        r_shift_en  <= 1'b1;
                    end else if (w_accept) begin
                        // the final word keeps only its upper LAST_BITS bits
                        r_head       <= cfg_data[WORD_W-1];
                        r_buf        <= cfg_data << 1;
                        r_buf_cnt    <= (r_words_left == WC_ONE) ? BC_TAIL : BC_FULL;
                        r_words_left <= r_words_left - WC_ONE;
                        r_bits_sent  <= r_bits_sent + BS_ONE;
                        r_shift_en   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 64-flop and a 12-flop chain model, directed and random passes.
module tb_ccff_chain_loader;
`ifdef CCFF_READBACK_EN
    localparam int EX0 = 64 + 65;
    localparam int EX1 = 12 + 13;
    localparam int GB  = 1;
`else
    localparam int EX0 = 0;
    localparam int EX1 = 0;
    localparam int GB  = 0;
`endif

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       start[2];
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       ready[2], head[2], shift_en[2], tail[2], busy[2], done[2], error[2];

    logic [63:0] chain[2];
    logic [5:0]  tail_idx[2];
    logic        prev_head[2] = '{1'b0, 1'b0};
    logic        busy_at_done[2];
    int          sh_cnt[2] = '{0, 0};
    int          hs_cnt[2] = '{0, 0};
    int          done_cnt[2] = '{0, 0};
    int          hold_viol[2] = '{0, 0};
    int          last_sh_cyc[2] = '{0, 0};
    int          done_cyc[2] = '{0, 0};
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  words[8];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(8)) dut0 (
        .prog_clk(prog_clk), .pReset(pReset), .cfg_start(start[0]), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(ready[0]), .ccff_head(head[0]),
        .ccff_shift_en(shift_en[0]), .ccff_tail(tail[0]), .busy(busy[0]), .done(done[0]),
        .error(error[0]));

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut1 (
        .prog_clk(prog_clk), .pReset(pReset), .cfg_start(start[1]), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(ready[1]), .ccff_head(head[1]),
        .ccff_shift_en(shift_en[1]), .ccff_tail(tail[1]), .busy(busy[1]), .done(done[1]),
        .error(error[1]));

    assign tail[0] = chain[0][tail_idx[0]];
    assign tail[1] = chain[1][tail_idx[1]];

    // Chain models plus per-DUT event counters
    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        for (int j = 0; j < 2; j++) begin
            if (shift_en[j] === 1'b1) begin
                chain[j]       <= {chain[j][62:0], head[j]};
                sh_cnt[j]      <= sh_cnt[j] + 1;
                last_sh_cyc[j] <= cyc;
            end
            if (cfg_valid === 1'b1 && ready[j] === 1'b1) hs_cnt[j] <= hs_cnt[j] + 1;
            if (done[j] === 1'b1) begin
                done_cnt[j]     <= done_cnt[j] + 1;
                done_cyc[j]     <= cyc;
                busy_at_done[j] <= busy[j];
            end
            if (busy[j] === 1'b1 && shift_en[j] === 1'b0 && head[j] !== prev_head[j])
                hold_viol[j] <= hold_viol[j] + 1;
            prev_head[j] <= head[j];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit p of the bitstream is bit 7-(p%8) of word p/8; after L shifts it sits L-1-p flops from the head
    function automatic logic [63:0] exp_chain(input int L);
        logic [63:0] v;
        v = '0;
        for (int p = 0; p < L; p++) v[L-1-p] = words[p/8][7-(p%8)];
        return v;
    endfunction

    task automatic run_pass(input int j, input int nwords, input int total, input int stall_word,
                            input int abort_bit, output int sh, output int hs, output int gaps,
                            output int lat_err, output bit ok);
        int  sh0, hs0, hs_prev, idx, stall_left;
        bit  stall_done;
        sh0 = sh_cnt[j]; hs0 = hs_cnt[j]; hs_prev = 0;
        gaps = 0; lat_err = 0; ok = 1'b0; stall_left = 0; stall_done = 1'b0;
        start[j] = 1'b1; cfg_valid = 1'b1; cfg_data = words[0];
        for (int b = 0; b < 2000; b++) begin
            @(negedge prog_clk);
            start[j] = 1'b0;
            idx = hs_cnt[j] - hs0;
            if (idx > hs_prev) begin
                if (!(shift_en[j] === 1'b1 && head[j] === words[idx-1][7])) lat_err++;
                hs_prev = idx;
            end
            if (abort_bit > 0 && sh_cnt[j] - sh0 >= abort_bit) begin
                pReset = 1'b1; ok = 1'b1; break;
            end
            if (done[j] === 1'b1 || error[j] === 1'b1) begin
                ok = 1'b1; break;
            end
            if (sh_cnt[j] - sh0 > 0 && sh_cnt[j] - sh0 < total && shift_en[j] !== 1'b1) gaps++;
            if (!stall_done && idx == stall_word && ready[j] === 1'b1) begin
                stall_done = 1'b1; stall_left = 4; cfg_valid = 1'b0;
            end else if (stall_left > 0) begin
                stall_left--;
            end else begin
                cfg_valid = (idx < nwords);
                cfg_data  = words[(idx < nwords) ? idx : 0];
            end
        end
        cfg_valid = 1'b0;
        sh = sh_cnt[j] - sh0;
        hs = hs_cnt[j] - hs0;
    endtask

    task automatic do_pass(input string t, input int j, input int L, input int nw, input int total,
                           input int stall_word, input int exp_gaps);
        int          sh, hs, gaps, lat, d0;
        bit          ok;
        logic [63:0] mask;
        d0 = done_cnt[j];
        run_pass(j, nw, total, stall_word, 0, sh, hs, gaps, lat, ok);
        chk({t, "_completed"}, 64'(ok), 64'd1);
        chk({t, "_shifts"}, 64'(sh), 64'(total));
        chk({t, "_handshakes"}, 64'(hs), 64'(nw));
        chk({t, "_gaps"}, 64'(gaps), 64'(exp_gaps));
        chk({t, "_first_bit_latency"}, 64'(lat), 64'd0);
        mask = (L >= 64) ? '1 : ((64'd1 << L) - 64'd1);
        chk({t, "_chain"}, chain[j] & mask, exp_chain(L));
        @(negedge prog_clk);
        chk({t, "_done_count"}, 64'(done_cnt[j] - d0), 64'd1);
        chk({t, "_done_timing"}, 64'(done_cyc[j]), 64'(last_sh_cyc[j] + 1));
        chk({t, "_busy_at_done"}, 64'(busy_at_done[j]), 64'd0);
        chk({t, "_done_falls"}, 64'(done[j]), 64'd0);
        chk({t, "_error"}, 64'(error[j]), 64'd0);
        chk({t, "_hold"}, 64'(hold_viol[j]), 64'd0);
    endtask

    initial begin
        int sh, hs, gaps, lat, d0;
        bit ok;
        pReset = 1'b1; start[0] = 1'b0; start[1] = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        tail_idx[0] = 6'd63; tail_idx[1] = 6'd11;
        repeat (3) @(negedge prog_clk);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_shift_en", 64'(shift_en[0]), 64'd0);
        chk("rst_ready", 64'(ready[0]), 64'd0);
        chk("rst_head", 64'(head[0]), 64'd0);
        chk("rst_done", 64'(done[0]), 64'd0);
        chk("rst_error", 64'(error[0]), 64'd0);
        chk("rst_busy12", 64'(busy[1]), 64'd0);
        pReset = 1'b0;
        @(negedge prog_clk);

        for (int i = 0; i < 8; i++) words[i] = 8'hA5;
        do_pass("a5", 0, 64, 8, 64 + EX0, -1, GB);

        words[0] = 8'hFF; words[1] = 8'hF0;
        do_pass("ff_f0", 1, 12, 2, 12 + EX1, -1, GB);

        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
            do_pass("rnd_nostall", 0, 64, 8, 64 + EX0, -1, GB);
            do_pass("rnd_stall", 0, 64, 8, 64 + EX0, 1 + it * 3, GB + 5);
        end

        for (int it = 0; it < 2; it++) begin
            words[0] = 8'($urandom); words[1] = 8'($urandom);
            do_pass("rnd12", 1, 12, 2, 12 + EX1, (it == 1) ? 1 : -1, GB + ((it == 1) ? 5 : 0));
        end

        for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
        run_pass(0, 8, 64 + EX0, -1, 30, sh, hs, gaps, lat, ok);
        chk("abort_reached", 64'(ok), 64'd1);
        @(negedge prog_clk);
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_shift_en", 64'(shift_en[0]), 64'd0);
        chk("abort_ready", 64'(ready[0]), 64'd0);
        chk("abort_done", 64'(done[0]), 64'd0);
        pReset = 1'b0;
        @(negedge prog_clk);
        for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
        do_pass("after_rst", 0, 64, 8, 64 + EX0, -1, GB);

`ifdef CCFF_READBACK_EN
        tail_idx[0] = 6'd62;
        d0 = done_cnt[0];
        run_pass(0, 8, 64 + EX0, -1, 0, sh, hs, gaps, lat, ok);
        chk("short_chain_stopped", 64'(ok), 64'd1);
        chk("short_chain_error", 64'(error[0]), 64'd1);
        chk("short_chain_no_words", 64'(hs), 64'd0);
        chk("short_chain_done_low", 64'(done[0]), 64'd0);
        @(negedge prog_clk);
        chk("err_to_idle", 64'(busy[0]), 64'd0);
        chk("error_sticky", 64'(error[0]), 64'd1);
        chk("short_chain_no_done", 64'(done_cnt[0] - d0), 64'd0);
        tail_idx[0] = 6'd63;
        do_pass("after_err", 0, 64, 8, 64 + EX0, -1, GB);
`else
        chk("error_tied_low", 64'(error[0]), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 The module SHALL have parameter CHAIN_LEN, default 64, meaning the number of configuration flops in the downstream ccff chain, legal range 2..4096.
REQ-002 The module SHALL have parameter WORD_W, default 8, meaning the width of a bitstream word, legal range 1..32.
REQ-003 Port prog_clk  input  1  is the only clock; all logic SHALL update on its rising edge.
REQ-004 Port pReset  input  1  is the reset, synchronous and active-high.
REQ-005 Port cfg_start  input  1  requests a programming pass; it is sampled only in IDLE.
REQ-006 Port cfg_data  input  WORD_W  carries the bitstream word; bit WORD_W-1 is shifted first.
REQ-007 Port cfg_valid  input  1  qualifies cfg_data.
REQ-008 Port cfg_ready  output  1  accepts a word; a word transfers when cfg_valid and cfg_ready are both high at a rising edge.
REQ-009 Port ccff_head  output  1  is the registered serial data driven into the head of the chain.
REQ-010 Port ccff_shift_en  output  1  is the registered chain shift enable, used to gate prog_clk to the chain; the chain advances one position only in cycles where it is high.
REQ-011 Port ccff_tail  input  1  is the chain tail, returned to the loader.
REQ-012 Outputs busy, done, and error SHALL each be 1 bit wide; they mean, respectively, a pass is active, a one-cycle success pulse, and a sticky failure flag.

Function
REQ-013 The state machine SHALL have the states IDLE, FLUSH, PROBE, LOAD, and ERR.
REQ-014 In IDLE, when cfg_start=1, the next state SHALL be FLUSH if CCFF_READBACK_EN is defined, and LOAD otherwise; a cfg_start while not in IDLE SHALL be ignored.
REQ-015 Accepting cfg_start SHALL clear error.
REQ-016 Each pass SHALL consume exactly ceil(CHAIN_LEN/WORD_W) words.
REQ-017 When CHAIN_LEN is not a multiple of WORD_W, the final word SHALL shift only its upper CHAIN_LEN mod WORD_W bits, and its remaining low bits SHALL be discarded.
REQ-018 cfg_ready SHALL be high only in LOAD, only while words remain, and only when the bit buffer is empty or is shifting its last bit in the current cycle, so that sustained throughput is one bit per cycle with no bubble.
REQ-019 A word accepted at edge k SHALL drive its first bit on ccff_head with ccff_shift_en=1 in cycle k+1.
REQ-020 When no bit is available in LOAD, ccff_shift_en SHALL be 0 and ccff_head SHALL hold its value.
REQ-021 In the cycle after the shift cycle of the CHAIN_LEN-th bit, done SHALL pulse for exactly 1 cycle, busy SHALL fall, and the state SHALL return to IDLE.
REQ-022 busy SHALL be 1 in every state other than IDLE.
REQ-023 ccff_shift_en SHALL be 0 in IDLE and in ERR.

Reset
REQ-024 pReset=1 SHALL force, on the next edge, state IDLE, ccff_head=0, ccff_shift_en=0, cfg_ready=0, busy=0, done=0, error=0, all counters 0, and the bit buffer empty.
REQ-025 A reset during FLUSH, PROBE, or LOAD SHALL abandon the pass without driving any further shift; the chain contents are then undefined, and software SHALL restart the pass.

Configuration
REQ-026 The macro CCFF_READBACK_EN SHALL enable a chain-integrity probe ahead of LOAD; without the macro, the FLUSH and PROBE states and their counters SHALL not exist and error SHALL be tied to 0.
REQ-027 In FLUSH, the module SHALL drive CHAIN_LEN consecutive shift cycles with ccff_head=0, then enter PROBE.
REQ-028 In PROBE, the module SHALL drive one marker cycle with ccff_head=1, then zeros, with ccff_shift_en=1 throughout, while counting the cycles since the marker.
REQ-029 If ccff_tail=1 is first seen exactly CHAIN_LEN cycles after the marker cycle, the module SHALL go to LOAD.
REQ-030 If ccff_tail=1 is seen early, or is not seen by 2*CHAIN_LEN cycles after the marker, the module SHALL go to ERR, setting error=1 and leaving done low.
REQ-031 ERR SHALL return to IDLE on the next cycle, and error SHALL remain set until the next accepted cfg_start or reset.

Verification
REQ-032 With CHAIN_LEN=64, WORD_W=8, and no macro, back-to-back words 0xA5 x8 SHALL produce 64 contiguous shift cycles with ccff_head following the pattern 1,0,1,0,0,1,0,1 and repeating, followed by done for 1 cycle, with the chain model holding the bitstream.
REQ-033 With CHAIN_LEN=12, WORD_W=8, and words 0xFF then 0xF0, the bench SHALL observe exactly 12 shift cycles, all with ccff_head=1, and 2 word handshakes.
REQ-034 With cfg_valid withheld for 5 cycles mid-pass, ccff_shift_en SHALL stay 0 for those cycles, ccff_head SHALL hold, and the final chain contents SHALL be unchanged versus the no-stall case.
REQ-035 With CCFF_READBACK_EN and a 64-flop chain model, FLUSH SHALL last 64 cycles, the tail marker SHALL appear after 64 cycles, then LOAD SHALL follow and done SHALL pulse; with a 63-flop model, error SHALL be 1, done SHALL stay 0, and no word SHALL be accepted.
REQ-036 With pReset asserted at bit 30 of LOAD, the next cycle SHALL show busy=0, ccff_shift_en=0, and cfg_ready=0, and a new cfg_start SHALL then complete a full 64-bit pass.
